// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
package mul_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mul_iter_cnt.sv
// Iteration counter for the multiplier controller: synchronous clear, count enable,
// terminal-count flag raised while the count equals WIDTH-1.
module mul_iter_cnt #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_ctrl.sv
// Control FSM for a shift-add multiplier datapath (IDLE -> LOAD -> CALC -> DONE).
// Optional feature: define MUL_CTRL_EARLY_DONE_EN to leave CALC as soon as q_zero is seen.
module mul_ctrl
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   ack,
   input  logic                   q0,
   input  logic                   q_zero,
   output logic                   load,
   output logic                   add,
   output logic                   shift,
   output logic                   busy,
   output logic                   readyR,
   output logic [$clog2(WIDTH):0] cnt,
   output logic [1:0]             state_dbg
);

   // Handshake: start is a request sampled only in IDLE; readyR holds in DONE
   // until ack is sampled, and ack anywhere else is ignored.
   state_t state, state_nxt;
   logic   cnt_clear, cnt_en, cnt_tc;
   logic   calc_exit;

   mul_iter_cnt #(.WIDTH(WIDTH)) u_iter_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .cnt    (cnt),
      .tc     (cnt_tc)
   );

`ifdef MUL_CTRL_EARLY_DONE_EN
   assign calc_exit = cnt_tc | q_zero;
`else
   logic unused_q_zero;
   assign unused_q_zero = q_zero;
   assign calc_exit     = cnt_tc;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      add       = 1'b0;
      shift     = 1'b0;
      busy      = 1'b0;
      readyR    = 1'b0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      unique case (state)
         IDLE: begin
            // Holding the counter clear here makes cnt read 0 throughout LOAD.
            cnt_clear = 1'b1;
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            load      = 1'b1;
            busy      = 1'b1;
            cnt_clear = 1'b1;
            state_nxt = CALC;
         end
         CALC: begin
            busy   = 1'b1;
            shift  = 1'b1;
            add    = q0;
            cnt_en = 1'b1;
            if (calc_exit) state_nxt = DONE;
         end
         DONE: begin
            readyR = 1'b1;
            if (ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: behavioural shift-add datapath around the controller, vector table,
// product scoreboard and hand-written reset / handshake sequences.
module tb_mul_ctrl;
   import mul_pkg::*;

   localparam int W  = 8;
   localparam int CW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          reset, start, ack, q0, q_zero;
   logic          load, add, shift, busy, readyR;
   logic [CW-1:0] cnt;
   logic [1:0]    state_dbg;

   mul_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .ack(ack), .q0(q0), .q_zero(q_zero),
      .load(load), .add(add), .shift(shift), .busy(busy), .readyR(readyR),
      .cnt(cnt), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // datapath model: multiplicand m_a, multiplier m_b, product {m_hi, m_lo}
   logic [W-1:0] cur_a, cur_b, m_a, m_b, m_hi, m_lo;
   logic [W:0]   m_sum;
   assign m_sum  = {1'b0, m_hi} + (add ? {1'b0, m_a} : '0);
   assign q0     = m_b[0];
   assign q_zero = (m_b[W-1:1] == '0);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_a <= '0; m_b <= '0; m_hi <= '0; m_lo <= '0;
      end else if (load) begin
         m_a <= cur_a; m_b <= cur_b; m_hi <= '0; m_lo <= '0;
      end else if (shift) begin
         m_hi <= m_sum[W:1];
         m_lo <= {m_sum[0], m_lo[W-1:1]};
         m_b  <= m_b >> 1;
      end
   end

   int tests = 0;
   int fails = 0;
   logic [2*W-1:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int exp_calc(input logic [W-1:0] b);
      int n;
      n = W;
`ifdef MUL_CTRL_EARLY_DONE_EN
      n = 1;
      for (int i = 1; i < W; i++) if (b[i]) n = i + 1;
`endif
      return n;
   endfunction

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] prod;
      int             adds;
   } vec_t;
   vec_t vecs[6];

   task automatic run_vec(input vec_t v);
      int ncalc, shifts, adds, loads, seq_err, rdy_cycle, hold_err;
      logic [2*W-1:0] exp_p, got_p;
      ncalc = exp_calc(v.b);
      shifts = 0; adds = 0; loads = 0; seq_err = 0; rdy_cycle = -1; hold_err = 0;
      cur_a = v.a; cur_b = v.b;
      exp_q.push_back(v.prod);
      start = 1'b1;
      for (int c = 1; c <= 40 && rdy_cycle < 0; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (load) begin loads++; if (c != 1) seq_err++; end
         if (shift) shifts++;
         if (add) adds++;
         if (c == 1 && !(busy && cnt == 0 && state_dbg == LOAD)) seq_err++;
         if (c >= 2 && c <= ncalc + 1 &&
             !(busy && shift && !readyR && cnt == CW'(c - 2) && state_dbg == CALC)) seq_err++;
         if (readyR) begin
            rdy_cycle = c;
            if (busy || load || shift || add) seq_err++;
         end
      end
      check("ready_cycle", rdy_cycle, ncalc + 2);
      check("load_pulses", loads, 1);
      check("shift_pulses", shifts, ncalc);
      check("add_pulses", adds, v.adds);
      check("sequence", seq_err, 0);
      exp_p = exp_q.pop_front();
      got_p = {m_hi, m_lo} >> (W - shifts);
      if (rdy_cycle < 0) check("ready_timeout", 0, 1);
      else check("product", int'(got_p), int'(exp_p));
      // DONE must hold without ack
      ack = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (!readyR || busy || state_dbg != DONE) hold_err++;
      end
      check("done_hold", hold_err, 0);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("ack_to_idle", {readyR, busy, state_dbg}, {1'b0, 1'b0, IDLE});
   endtask

   initial begin
      int loads, waited, rdy_seen;
      vecs[0] = '{8'hE9, 8'hC3, 16'hB17B, 4};
      vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 8};
      vecs[2] = '{8'h00, 8'h55, 16'h0000, 4};
      vecs[3] = '{8'h12, 8'h00, 16'h0000, 0};
      vecs[4] = '{8'h01, 8'h80, 16'h0080, 1};
      vecs[5] = '{8'hA5, 8'h03, 16'h01EF, 2};

      reset = 1'b0; start = 1'b0; ack = 1'b0; cur_a = '0; cur_b = '0;
      #3;
      check("reset_outputs", {load, add, shift, busy, readyR}, 0);
      check("reset_state", {cnt, state_dbg}, {CW'(0), IDLE});
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // asynchronous reset in the middle of CALC
      cur_a = 8'h5A; cur_b = 8'hC3;
      start = 1'b1;
      waited = 0;
      @(negedge clk);
      start = 1'b0;
      while (!(state_dbg == CALC && cnt == CW'(3)) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("reach_cnt3", waited < 20, 1);
      #2 reset = 1'b0;
      #1;
      check("midcalc_reset_outputs", {load, add, shift, busy, readyR}, 0);
      check("midcalc_reset_state", {cnt, state_dbg}, {CW'(0), IDLE});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {busy, state_dbg}, {1'b0, IDLE});

      // start in CALC ignored; start with ack in DONE returns to IDLE only
      cur_a = 8'h37; cur_b = 8'hF0;
      loads = 0; rdy_seen = 0;
      start = 1'b1;
      for (int c = 1; c <= 40 && !rdy_seen; c++) begin
         @(negedge clk);
         start = (c == 4);
         if (load) loads++;
         if (readyR) rdy_seen = 1;
      end
      check("calc_start_ready", rdy_seen, 1);
      start = 1'b1; ack = 1'b1;
      @(negedge clk);
      start = 1'b0; ack = 1'b0;
      if (load) loads++;
      check("start_ack_idle", {readyR, state_dbg}, {1'b0, IDLE});
      repeat (5) begin
         @(negedge clk);
         if (load) loads++;
      end
      check("no_queued_load", loads, 1);
      check("still_idle", state_dbg, IDLE);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_load", {load, state_dbg}, {1'b1, LOAD});
      repeat (W + 2) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
